// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types, defaults and stage-distance helper for the serial right shifter
package shift_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int SHAMT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Distance handled by barrel stage k: stage k covers shift-amount bit k.
    function automatic int stage_dist(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/shift_right_stage.sv
// rtl/shift_right_stage.sv - one combinational barrel stage shifting right by a fixed distance
module shift_right_stage
    import shift_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int DIST = 1
) (
    input  logic [XLEN-1:0] i_data,
    input  logic            i_enable,
    input  logic            i_fill,
    output logic [XLEN-1:0] o_data
);

    // Shift right by DIST with the vacated top bits taken from the fill bit.
    always_comb begin
        o_data = i_data;
        if (i_enable) begin
            o_data = {{DIST{i_fill}}, i_data[XLEN-1:DIST]};
        end
    end

endmodule

// File: rtl/shift_right_serial.sv
// rtl/shift_right_serial.sv - multi-cycle SRL/SRA/SRLW/SRAW unit, one barrel stage per cycle
module shift_right_serial
    import shift_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_arith,
    input  logic               in_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_data
);

    localparam int K_W = $clog2(SHAMT_W);

    state_t             r_state;
    state_t             w_next_state;
    logic [XLEN-1:0]    r_acc;
    logic [XLEN-1:0]    r_out_data;
    logic [SHAMT_W-1:0] r_amt;
    logic               r_fill;
    logic               r_word;
    logic [K_W-1:0]     r_k;

    logic               w_accept;
    logic               w_last;
    logic [XLEN-1:0]    w_load_acc;
    logic [SHAMT_W-1:0] w_load_amt;
    logic [XLEN-1:0]    w_stage [SHAMT_W];
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_result;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_k == K_W'(SHAMT_W - 1));

    // W-variants operate on the low word pre-extended by the fill, and ignore the top amount bit.
    assign w_load_acc = in_word ? {{(XLEN-32){in_arith & in_data[31]}}, in_data[31:0]} : in_data;
    assign w_load_amt = in_word ? {{(SHAMT_W-5){1'b0}}, in_shamt[4:0]} : in_shamt;

    // One fixed-distance stage per amount bit; only the stage for the current k is used.
    for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
        shift_right_stage #(
            .XLEN (XLEN),
            .DIST (stage_dist(g))
        ) u_stage (
            .i_data   (r_acc),
            .i_enable (r_amt[g]),
            .i_fill   (r_fill),
            .o_data   (w_stage[g])
        );
    end

    // Select the stage output addressed by the stage counter.
    always_comb begin
        w_shifted = r_acc;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (r_k == K_W'(i)) begin
                w_shifted = w_stage[i];
            end
        end
    end

    // Word results are the sign-extension of the low 32 bits of the final accumulator.
    assign w_result = r_word ? {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]} : w_shifted;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; a new request is taken only from IDLE.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: load on acceptance, one stage per SHIFT cycle, capture the result on the last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            r_amt      <= '0;
            r_fill     <= 1'b0;
            r_word     <= 1'b0;
            r_k        <= '0;
            r_out_data <= '0;
        end else if (w_accept) begin
            r_acc  <= w_load_acc;
            r_amt  <= w_load_amt;
            r_fill <= in_arith & w_load_acc[XLEN-1];
            r_word <= in_word;
            r_k    <= '0;
        end else if (r_state == SHIFT) begin
            r_acc <= w_shifted;
            r_k   <= r_k + 1'b1;
            if (w_last) begin
                r_out_data <= w_result;
            end
        end
    end

    assign out_data = r_out_data;

endmodule

// File: tb/tb_shift_right_serial.sv
// tb/tb_shift_right_serial.sv - directed and randomized self-checking bench for shift_right_serial
module tb_shift_right_serial;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    logic        in_arith;
    logic        in_word;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;

    shift_right_serial dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic [5:0] s,
                                              input logic a, input logic w);
        logic [31:0] lo;
        if (w) begin
            lo = a ? 32'($signed(d[31:0]) >>> s[4:0]) : (d[31:0] >> s[4:0]);
            return {{32{lo[31]}}, lo};
        end
        return a ? 64'($signed(d) >>> s) : (d >> s);
    endfunction

    // Issue one request, measure latency, take the result immediately.
    task automatic do_op(input string tag, input logic [63:0] d, input logic [5:0] s,
                         input logic a, input logic w, input logic [63:0] exp);
        int lat;
        @(negedge clk);
        in_data = d; in_shamt = s; in_arith = a; in_word = w; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd6);
        check({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    logic [63:0] exp_q[$];
    int          n_rx;
    int          seen_valid;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0;
        in_arith = 1'b0; in_word = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        reset = 1'b0;

        do_op("srl63", 64'h8000_0000_0000_0000, 6'd63, 1'b0, 1'b0, 64'h0000_0000_0000_0001);
        do_op("sra4",  64'h8000_0000_0000_0000, 6'd4,  1'b1, 1'b0, 64'hF800_0000_0000_0000);
        do_op("sra63", 64'h8000_0000_0000_0000, 6'd63, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op("srlw",  64'hFFFF_FFFF_8000_0000, 6'h21, 1'b0, 1'b1, 64'h0000_0000_4000_0000);
        do_op("sraw",  64'h0000_0000_8000_0000, 6'd4,  1'b1, 1'b1, 64'hFFFF_FFFF_F800_0000);
        do_op("srl13", 64'hF0F0_0000_0000_1234, 6'd13, 1'b0, 1'b0, 64'h0007_8780_0000_0000);

        // Zero shift under backpressure, with a competing request held on the input.
        @(negedge clk);
        in_data = 64'h0123_4567_89AB_CDEF; in_shamt = 6'd0; in_arith = 1'b0; in_word = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = 64'hDEAD_BEEF_DEAD_BEEF; in_shamt = 6'd7;
        repeat (6) @(negedge clk);
        check("bp_valid_at6", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_hold", 64'(out_valid), 64'd1);
            check("bp_data_hold", out_data, 64'h0123_4567_89AB_CDEF);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp_vld_drop", 64'(out_valid), 64'd0);
        check("bp_rdy_back", 64'(in_ready), 64'd1);

        // Reset three cycles into an operation aborts it.
        @(negedge clk);
        in_data = 64'hFFFF_0000_FFFF_0000; in_shamt = 6'd8; in_arith = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", out_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("abort_no_pulse", 64'(seen_valid), 64'd0);
        do_op("post_rst", 64'hFFFF_0000_FFFF_0000, 6'd8, 1'b1, 1'b0, 64'hFFFF_FF00_00FF_FF00);

        // Random stream with gaps and backpressure, scoreboarded in order.
        n_rx = 0;
        fork
            begin
                for (int t = 0; t < 1000; t++) begin
                    logic [63:0] d;
                    logic [5:0]  s;
                    logic        a, w;
                    int          tries;
                    @(negedge clk);
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    d = {$urandom, $urandom};
                    s = 6'($urandom);
                    a = 1'($urandom);
                    w = 1'($urandom);
                    in_data = d; in_shamt = s; in_arith = a; in_word = w; in_valid = 1'b1;
                    tries = 0;
                    while (!in_ready && tries < 200) begin
                        @(negedge clk);
                        tries++;
                    end
                    exp_q.push_back(ref_shift(d, s, a, w));
                    @(posedge clk);
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 60000 && n_rx < 1000; c++) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_unexpected", out_data, 64'hX);
                        end else begin
                            check("rand_data", out_data, exp_q.pop_front());
                        end
                        n_rx++;
                    end
                end
                out_ready = 1'b0;
            end
        join
        check("rand_count", 64'(n_rx), 64'd1000);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
